// File: rtl/nr_fetch_pkg.sv
// Shared definitions for the nanoRisk fetch stage: FSM states and the
// default bus widths also used by the register bank and decoder.
package nr_fetch_pkg;

   localparam int unsigned NR_ADDR_W = 4;
   localparam int unsigned NR_DATA_W = 8;
   localparam int unsigned NR_DEPTH  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/nr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory read port, redirect/halt
// controls and the instruction handshake toward decode.
interface nr_fetch_unit_if #(
   parameter int unsigned ADDR_W = nr_fetch_pkg::NR_ADDR_W,
   parameter int unsigned DATA_W = nr_fetch_pkg::NR_DATA_W
);

   logic              imem_rd;
   logic [ADDR_W-1:0] imem_adr;
   logic [DATA_W-1:0] imem_data;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_adr;
   logic              halt;
   logic              ins_valid;
   logic [DATA_W-1:0] ins_out;
   logic [ADDR_W-1:0] ins_pc;
   logic              ins_ready;

   modport master (
      output imem_rd, imem_adr, ins_valid, ins_out, ins_pc,
      input  imem_data, redirect, redirect_adr, halt, ins_ready
   );

   modport slave (
      input  imem_rd, imem_adr, ins_valid, ins_out, ins_pc,
      output imem_data, redirect, redirect_adr, halt, ins_ready
   );

endinterface

// File: rtl/nr_fetch_fifo.sv
// Prefetch buffer of {pc, data} pairs; flush drops every entry while a
// concurrent pop still sees the old head for that cycle.
module nr_fetch_fifo #(
   parameter  int unsigned ADDR_W = 4,
   parameter  int unsigned DATA_W = 8,
   parameter  int unsigned DEPTH  = 2,
   localparam int unsigned PW     = $clog2(DEPTH),
   localparam int unsigned CW     = PW + 1
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              push_i,
   input  logic [ADDR_W-1:0] push_pc_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   input  logic              flush_i,
   output logic [CW-1:0]     count_o,
   output logic              valid_o,
   output logic [ADDR_W-1:0] head_pc_o,
   output logic [DATA_W-1:0] head_data_o
);

   logic [ADDR_W-1:0] pc_q   [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PW-1:0]     rd_q, rd_d;
   logic [PW-1:0]     wr_q, wr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              do_push;
   logic              do_pop;

   assign valid_o     = (cnt_q != '0);
   assign do_pop      = pop_i & valid_o;
   assign do_push     = push_i & ~flush_i;
   assign count_o     = cnt_q;
   assign head_pc_o   = pc_q[rd_q];
   assign head_data_o = data_q[rd_q];

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + PW'(1);
         if (do_pop)  rd_d = rd_q + PW'(1);
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            pc_q[i]   <= '0;
            data_q[i] <= '0;
         end
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
         if (do_push) begin
            pc_q[wr_q]   <= push_pc_i;
            data_q[wr_q] <= push_data_i;
         end
      end
   end

endmodule

// File: rtl/nr_fetch_unit.sv
// nanoRisk instruction fetch: PC, fetch FSM, single in-flight read tracking
// and issue throttling so the prefetch buffer can never overflow.
module nr_fetch_unit
   import nr_fetch_pkg::*;
#(
   parameter  int unsigned ADDR_W = NR_ADDR_W,
   parameter  int unsigned DATA_W = NR_DATA_W,
   parameter  int unsigned DEPTH  = NR_DEPTH,
   localparam int unsigned CW     = $clog2(DEPTH) + 1,
   localparam int unsigned OW     = CW + 1
) (
   input  logic            clk,
   input  logic            clr,
   nr_fetch_unit_if.master bus
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              infl_q, infl_d;
   logic [ADDR_W-1:0] tag_q, tag_d;
   logic              issue;
   logic              pop;
   logic              push;
   logic              redirect_act;
   logic [CW-1:0]     count;
   logic [OW-1:0]     occ;
   logic              head_valid;
   logic [ADDR_W-1:0] head_pc;
   logic [DATA_W-1:0] head_data;

   assign pop          = head_valid & bus.ins_ready;
   assign redirect_act = bus.redirect & (state_q != IDLE);
   // Slots already claimed next cycle: buffered entries plus the returning read, less this pop
   assign occ          = OW'(count) + OW'(infl_q) - OW'(pop);
   // A redirected read's data arrives in the redirect cycle and is dropped there
   assign push         = infl_q & ~redirect_act;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      infl_d  = 1'b0;
      tag_d   = tag_q;
      issue   = 1'b0;

      unique case (state_q)
         IDLE:    state_d = FETCH;
         FETCH:   if (bus.halt)  state_d = HOLD;
         HOLD:    if (!bus.halt) state_d = FETCH;
         default: state_d = IDLE;
      endcase

      issue = (state_q == FETCH) & ~bus.halt & ~bus.redirect & (occ < OW'(DEPTH));

      if (issue) begin
         pc_d   = pc_q + ADDR_W'(1);
         infl_d = 1'b1;
         tag_d  = pc_q;
      end
      if (redirect_act) pc_d = bus.redirect_adr;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= IDLE;
         pc_q    <= '0;
         infl_q  <= 1'b0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         infl_q  <= infl_d;
         tag_q   <= tag_d;
      end
   end

   nr_fetch_fifo #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .clr         (clr),
      .push_i      (push),
      .push_pc_i   (tag_q),
      .push_data_i (bus.imem_data),
      .pop_i       (pop),
      .flush_i     (redirect_act),
      .count_o     (count),
      .valid_o     (head_valid),
      .head_pc_o   (head_pc),
      .head_data_o (head_data)
   );

   assign bus.imem_rd   = issue;
   assign bus.imem_adr  = pc_q;
   assign bus.ins_valid = head_valid;
   assign bus.ins_pc    = head_pc;
   assign bus.ins_out   = head_data;

endmodule

// File: tb/tb_nr_fetch_unit.sv
// Directed bench for nr_fetch_unit: a memory model answering adr+8'h10 and a
// scoreboard of expected {pc, data} fed from the bench's own PC model.
module tb_nr_fetch_unit;

   typedef struct packed {
      logic [3:0] pc;
      logic [7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic clr;

   nr_fetch_unit_if #(.ADDR_W(4), .DATA_W(8)) bus ();

   nr_fetch_unit #(.ADDR_W(4), .DATA_W(8), .DEPTH(2)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int         checks      = 0;
   int         errors      = 0;
   int         cyc         = 0;
   int         first_rd    = -1;
   int         first_valid = -1;
   int         first_pop   = -1;
   int         rd_cnt      = 0;
   int         r_cyc       = 0;
   exp_t       sb[$];
   logic [3:0] seen[$];
   logic [3:0] exp_pc  = 4'd0;
   logic [3:0] h_pc    = 4'd0;
   logic       obs_rd  = 1'b0;
   logic [3:0] obs_adr = 4'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_seq(input string tag, input logic [3:0] start, input int n);
      chk({tag, "_len"}, seen.size(), n);
      for (int i = 0; i < n; i++)
         if (i < seen.size()) chk(tag, seen[i], 4'(start + 4'(i)));
   endtask

   // One clock: observe mid-cycle, update model/scoreboard, then answer memory.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      obs_rd  = bus.imem_rd;
      obs_adr = bus.imem_adr;
      if (!clr) begin
         if (bus.ins_valid && bus.ins_ready) begin
            if (first_valid < 0) first_valid = cyc;
            if (seen.size() == 0) first_pop = cyc;
            seen.push_back(bus.ins_pc);
            checks++;
            assert (sb.size() != 0) else begin
               errors++;
               $error("FAIL sb_unexpected observed_pc=%0h expected=none", bus.ins_pc);
            end
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("ins_pc", bus.ins_pc, e.pc);
               chk("ins_out", bus.ins_out, e.data);
            end
         end
         if (bus.redirect) begin
            sb.delete();
            exp_pc = bus.redirect_adr;
         end
         if (bus.imem_rd) begin
            if (first_rd < 0) first_rd = cyc;
            rd_cnt++;
            chk("imem_adr", bus.imem_adr, exp_pc);
            e.pc   = exp_pc;
            e.data = 8'(exp_pc) + 8'h10;
            sb.push_back(e);
            exp_pc = exp_pc + 4'd1;
         end
      end
      @(posedge clk);
      #1;
      bus.imem_data = obs_rd ? (8'(obs_adr) + 8'h10) : 8'hA5;
      cyc++;
   endtask

   task automatic run_until(input int n, input int max_cycles);
      for (int i = 0; i < max_cycles && seen.size() < n; i++) tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      clr              = 1'b1;
      bus.imem_data    = 8'h00;
      bus.redirect     = 1'b0;
      bus.redirect_adr = 4'h0;
      bus.halt         = 1'b0;
      bus.ins_ready    = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_imem_rd", bus.imem_rd, 0);
      chk("rst_imem_adr", bus.imem_adr, 0);
      chk("rst_ins_valid", bus.ins_valid, 0);
      chk("rst_ins_out", bus.ins_out, 0);
      chk("rst_ins_pc", bus.ins_pc, 0);

      // start-up stream
      clr = 1'b0;
      cyc = 0;
      repeat (8) tick();
      chk("start_first_rd", first_rd, 1);
      chk("start_first_valid", first_valid, 3);
      chk_seq("start_seq", 4'h0, 5);

      // backpressure: head 5 held, buffer full, no reads
      bus.ins_ready = 1'b0;
      seen.delete();
      rd_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_valid", bus.ins_valid, 1);
         chk("bp_pc", bus.ins_pc, 5);
         chk("bp_out", bus.ins_out, 8'h15);
      end
      chk("bp_rd_cnt", rd_cnt, 0);
      chk("bp_no_pop", seen.size(), 0);
      bus.ins_ready = 1'b1;
      repeat (4) tick();
      chk_seq("bp_resume", 4'h5, 4);

      // redirect to E and wrap through F -> 0
      bus.redirect     = 1'b1;
      bus.redirect_adr = 4'hE;
      r_cyc = cyc;
      tick();
      chk("redir_no_rd", obs_rd, 0);
      bus.redirect = 1'b0;
      seen.delete();
      first_pop = -1;
      run_until(4, 12);
      chk_seq("wrap_seq", 4'hE, 4);
      chk("redir_lat", first_pop, r_cyc + 3);

      // read to 3 in flight when redirecting to 7
      bus.redirect     = 1'b1;
      bus.redirect_adr = 4'h3;
      tick();
      bus.redirect = 1'b0;
      tick();
      chk("infl_rd", obs_rd, 1);
      chk("infl_adr", obs_adr, 3);
      bus.redirect     = 1'b1;
      bus.redirect_adr = 4'h7;
      tick();
      chk("redir7_no_rd", obs_rd, 0);
      bus.redirect = 1'b0;
      seen.delete();
      run_until(2, 10);
      chk_seq("discard_seq", 4'h7, 2);

      // halt while streaming
      h_pc = exp_pc;
      seen.delete();
      rd_cnt   = 0;
      bus.halt = 1'b1;
      repeat (4) tick();
      bus.halt = 1'b0;
      chk("halt_rd_cnt", rd_cnt, 0);
      chk_seq("halt_drain", 4'(h_pc - 4'd2), 2);
      seen.delete();
      run_until(2, 10);
      chk_seq("halt_resume", h_pc, 2);

      // mid-stream clear
      repeat (3) tick();
      clr = 1'b1;
      #1;
      chk("clr_imem_rd", bus.imem_rd, 0);
      chk("clr_imem_adr", bus.imem_adr, 0);
      chk("clr_ins_valid", bus.ins_valid, 0);
      chk("clr_ins_out", bus.ins_out, 0);
      chk("clr_ins_pc", bus.ins_pc, 0);
      sb.delete();
      seen.delete();
      exp_pc = 4'd0;
      tick();
      clr         = 1'b0;
      cyc         = 0;
      first_rd    = -1;
      first_valid = -1;
      repeat (6) tick();
      chk("clr_first_rd", first_rd, 1);
      chk("clr_first_valid", first_valid, 3);
      chk_seq("clr_seq", 4'h0, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
